output_arbiter: RTL and testbench

Clocked 2-to-1 round-robin arbiter for the NoC tree router output port. It merges packets from two input controllers (the child-side and parent-side `input_ctrl` instances steering to the same direction) onto one output link. All three links use a 4-phase bundled-data req/ack handshake. Each packet is held in a one-entry register while it is forwarded, and per-input grant counters are kept for debug and coverage.

---
 rtl/output_arbiter.sv | 154 +++++++++++++++
 tb/tb_output_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_arbiter
// Description : 2-to-1 round-robin arbiter for one NoC router output link.
//               Both inputs and the output use a 4-phase req/ack handshake.
//               The winning packet is held in a one-entry register while it
//               is forwarded. Per-input grant counters are kept for debug.
// Revision    : 1.0 - initial release
// ============================================================================
module output_arbiter #(
    parameter int WIDTH_packet = 14,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in0_req,
    input  logic [WIDTH_packet-1:0] in0_data,
    output logic                    in0_ack,
    input  logic                    in1_req,
    input  logic [WIDTH_packet-1:0] in1_data,
    output logic                    in1_ack,
    output logic                    out_req,
    output logic [WIDTH_packet-1:0] out_data,
    input  logic                    out_ack,
    output logic [CNT_W-1:0]        grant_cnt0,
    output logic [CNT_W-1:0]        grant_cnt1
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // IDLE    : waiting for a request
    // SEND    : out_req high, waiting for out_ack
    // OUT_RTZ : out_req low, waiting for out_ack to return to zero
    // IN_ACK  : in_ack[gnt] high, waiting for the granted sender to drop req
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_OUT_RTZ = 2'd2,
        S_IN_ACK  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_prio;
    logic                    w_prio_nxt;
    logic                    r_gnt;
    logic                    w_gnt_nxt;
    logic                    w_win;
    logic                    w_gnt_req;
    logic [WIDTH_packet-1:0] r_data;
    logic [WIDTH_packet-1:0] w_data_nxt;
    logic                    r_out_req;
    logic                    w_out_req_nxt;
    logic [1:0]              r_in_ack;
    logic [1:0]              w_in_ack_nxt;
    logic [CNT_W-1:0]        r_cnt0;
    logic [CNT_W-1:0]        r_cnt1;
    logic [CNT_W-1:0]        w_cnt0_nxt;
    logic [CNT_W-1:0]        w_cnt1_nxt;

    // Request line of the input currently holding the grant.
    always_comb begin
        w_gnt_req = r_gnt ? in1_req : in0_req;
    end

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        w_state_nxt   = r_state;
        w_prio_nxt    = r_prio;
        w_gnt_nxt     = r_gnt;
        w_data_nxt    = r_data;
        w_out_req_nxt = r_out_req;
        w_in_ack_nxt  = r_in_ack;
        w_cnt0_nxt    = r_cnt0;
        w_cnt1_nxt    = r_cnt1;
        w_win         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in0_req || in1_req) begin
                    // A tie goes to prio; otherwise the lone requester wins.
                    if (in0_req && in1_req) begin
                        w_win = r_prio;
                    end else begin
                        w_win = in1_req;
                    end
                    w_gnt_nxt     = w_win;
                    w_data_nxt    = w_win ? in1_data : in0_data;
                    w_out_req_nxt = 1'b1;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ack) begin
                    w_out_req_nxt = 1'b0;
                    w_state_nxt   = S_OUT_RTZ;
                end
            end
            S_OUT_RTZ: begin
                if (!out_ack) begin
                    w_in_ack_nxt = r_gnt ? 2'b10 : 2'b01;
                    w_state_nxt  = S_IN_ACK;
                end
            end
            S_IN_ACK: begin
                if (!w_gnt_req) begin
                    // Packet complete: release the sender, hand priority over, count it.
                    w_in_ack_nxt = 2'b00;
                    w_prio_nxt   = ~r_gnt;
                    if (r_gnt) begin
                        w_cnt1_nxt = r_cnt1 + c_cnt_one;
                    end else begin
                        w_cnt0_nxt = r_cnt0 + c_cnt_one;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_prio    <= 1'b0;
            r_gnt     <= 1'b0;
            r_data    <= '0;
            r_out_req <= 1'b0;
            r_in_ack  <= 2'b00;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prio    <= w_prio_nxt;
            r_gnt     <= w_gnt_nxt;
            r_data    <= w_data_nxt;
            r_out_req <= w_out_req_nxt;
            r_in_ack  <= w_in_ack_nxt;
            r_cnt0    <= w_cnt0_nxt;
            r_cnt1    <= w_cnt1_nxt;
        end
    end

    assign in0_ack    = r_in_ack[0];
    assign in1_ack    = r_in_ack[1];
    assign out_req    = r_out_req;
    assign out_data   = r_data;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_arbiter
// Description : Self-checking bench for output_arbiter. Randomized senders and
//               receiver; a transaction-level round-robin model predicts the
//               order and content of forwarded packets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_arbiter;

    localparam int W   = 14;
    localparam int CW  = 4;
    localparam int BUD = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in0_req = 1'b0;
    logic [W-1:0]  in0_data = '0;
    logic          in0_ack;
    logic          in1_req = 1'b0;
    logic [W-1:0]  in1_data = '0;
    logic          in1_ack;
    logic          out_req;
    logic [W-1:0]  out_data;
    logic          out_ack = 1'b0;
    logic [CW-1:0] grant_cnt0;
    logic [CW-1:0] grant_cnt1;

    int checks = 0;
    int errors = 0;

    // Packets each sender will offer, in order.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    // Monitor log: one entry per grant (out_req rising).
    logic [W-1:0] log_data[$];
    logic [1:0]   log_req[$];
    int           log_cyc[$];
    int           ack0_rises = 0;
    int           ack1_rises = 0;
    int           viol = 0;
    int           cyc = 0;

    // Model output.
    logic [W-1:0] exp_data[$];
    int           model_bad;

    logic         s_req0 = 1'b0, s_req1 = 1'b0, s_rst = 1'b0, s_oack = 1'b0;
    logic         p_out_req = 1'b0, p_ack0 = 1'b0, p_ack1 = 1'b0;
    logic [W-1:0] p_out_data = '0;

    always #5 clk = ~clk;

    output_arbiter #(.WIDTH_packet(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_req    (in0_req),
        .in0_data   (in0_data),
        .in0_ack    (in0_ack),
        .in1_req    (in1_req),
        .in1_data   (in1_data),
        .in1_ack    (in1_ack),
        .out_req    (out_req),
        .out_data   (out_data),
        .out_ack    (out_ack),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    // What the DUT saw at each rising edge.
    always @(posedge clk) begin
        s_req0 <= in0_req;
        s_req1 <= in1_req;
        s_rst  <= rst_n;
        s_oack <= out_ack;
    end

    // Passive monitor: logs grants and counts protocol violations.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (s_rst) begin
            if (out_req && !p_out_req) begin
                log_data.push_back(out_data);
                log_req.push_back({s_req1, s_req0});
                log_cyc.push_back(cyc);
            end
            if (in0_ack && in1_ack) viol = viol + 1;
            if ((in0_ack || in1_ack) && out_req) viol = viol + 1;
            if (out_req && p_out_req && out_data !== p_out_data) viol = viol + 1;
            if (((in0_ack && !p_ack0) || (in1_ack && !p_ack1)) && s_oack) viol = viol + 1;
            if (in0_ack && !p_ack0) ack0_rises = ack0_rises + 1;
            if (in1_ack && !p_ack1) ack1_rises = ack1_rises + 1;
        end
        p_out_req  = out_req;
        p_out_data = out_data;
        p_ack0     = in0_ack;
        p_ack1     = in1_ack;
    end

    // Round-robin reference: for every logged grant, the winner is the lone
    // requester or, on a tie, the input not served last (input 0 after reset).
    function automatic void run_model(input int start);
        int pm = 0;
        int i0 = 0;
        int i1 = 0;
        int w;
        exp_data.delete();
        model_bad = 0;
        for (int i = start; i < log_req.size(); i++) begin
            if (log_req[i] == 2'b11)      w = pm;
            else if (log_req[i] == 2'b01) w = 0;
            else if (log_req[i] == 2'b10) w = 1;
            else begin model_bad++; w = -1; end
            if (w == 0 && i0 < q0.size()) begin exp_data.push_back(q0[i0]); i0++; end
            else if (w == 1 && i1 < q1.size()) begin exp_data.push_back(q1[i1]); i1++; end
            else begin model_bad++; exp_data.push_back('0); end
            if (w >= 0) pm = 1 - w;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in0_req = 1'b0; in1_req = 1'b0; out_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sender(input int src, input int first_dly, input int gapmax);
        int t;
        int n;
        n = (src == 0) ? q0.size() : q1.size();
        repeat (first_dly) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat ($urandom_range(gapmax, 0)) @(negedge clk);
            if (src == 0) begin in0_data = q0[i]; in0_req = 1'b1; end
            else          begin in1_data = q1[i]; in1_req = 1'b1; end
            t = 0;
            while (((src == 0) ? in0_ack : in1_ack) !== 1'b1 && t < BUD) begin @(negedge clk); t++; end
            checks++;
            if (t >= BUD) begin errors++; $display("FAIL sender%0d_ack_timeout: ack not seen within %0d cycles, expected 1", src, BUD); return; end
            if (src == 0) in0_req = 1'b0; else in1_req = 1'b0;
            t = 0;
            while (((src == 0) ? in0_ack : in1_ack) !== 1'b0 && t < BUD) begin @(negedge clk); t++; end
            checks++;
            if (t >= BUD) begin errors++; $display("FAIL sender%0d_ack_release_timeout: ack still 1, expected 0", src); return; end
        end
    endtask

    task automatic receiver(input int n, input int dmin, input int dmax);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (out_req !== 1'b1 && t < BUD) begin @(negedge clk); t++; end
            checks++;
            if (t >= BUD) begin errors++; $display("FAIL recv_req_timeout: out_req=%b, expected 1 within %0d cycles", out_req, BUD); return; end
            repeat ($urandom_range(dmax, dmin)) @(negedge clk);
            out_ack = 1'b1;
            t = 0;
            while (out_req !== 1'b0 && t < BUD) begin @(negedge clk); t++; end
            checks++;
            if (t >= BUD) begin errors++; $display("FAIL recv_rtz_timeout: out_req=%b, expected 0", out_req); return; end
            repeat ($urandom_range(dmax, dmin)) @(negedge clk);
            out_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in0_ack !== 1'b0)  begin errors++; $display("FAIL reset_in0_ack: got %b expected 0", in0_ack); end
        checks++; if (in1_ack !== 1'b0)  begin errors++; $display("FAIL reset_in1_ack: got %b expected 0", in1_ack); end
        checks++; if (out_req !== 1'b0)  begin errors++; $display("FAIL reset_out_req: got %b expected 0", out_req); end
        checks++; if (out_data !== '0)   begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (grant_cnt0 !== '0) begin errors++; $display("FAIL reset_cnt0: got %0d expected 0", grant_cnt0); end
        checks++; if (grant_cnt1 !== '0) begin errors++; $display("FAIL reset_cnt1: got %0d expected 0", grant_cnt1); end
    endtask

    task automatic test_single();
        int a0, a1;
        do_reset();
        a0 = ack0_rises; a1 = ack1_rises;
        in0_data = 14'h1A5; in0_req = 1'b1;
        @(negedge clk);
        checks++; if (out_req !== 1'b1)      begin errors++; $display("FAIL single_out_req_latency: got %b expected 1", out_req); end
        checks++; if (out_data !== 14'h1A5)  begin errors++; $display("FAIL single_out_data: got %h expected 1a5", out_data); end
        @(negedge clk); out_ack = 1'b1;
        @(negedge clk);
        checks++; if (out_req !== 1'b0)      begin errors++; $display("FAIL single_out_req_fall: got %b expected 0", out_req); end
        checks++; if (in0_ack !== 1'b0)      begin errors++; $display("FAIL single_in0_ack_early: got %b expected 0", in0_ack); end
        @(negedge clk); out_ack = 1'b0;
        @(negedge clk);
        checks++; if (in0_ack !== 1'b1)      begin errors++; $display("FAIL single_in0_ack_rise: got %b expected 1", in0_ack); end
        in0_req = 1'b0;
        @(negedge clk);
        checks++; if (in0_ack !== 1'b0)      begin errors++; $display("FAIL single_in0_ack_fall: got %b expected 0", in0_ack); end
        checks++; if (grant_cnt0 !== 4'd1)   begin errors++; $display("FAIL single_cnt0: got %0d expected 1", grant_cnt0); end
        checks++; if (grant_cnt1 !== 4'd0)   begin errors++; $display("FAIL single_cnt1: got %0d expected 0", grant_cnt1); end
        checks++; if (ack0_rises - a0 !== 1) begin errors++; $display("FAIL single_in0_ack_pulses: got %0d expected 1", ack0_rises - a0); end
        checks++; if (ack1_rises - a1 !== 0) begin errors++; $display("FAIL single_in1_ack_pulses: got %0d expected 0", ack1_rises - a1); end
    endtask

    task automatic test_simultaneous();
        int start, v0;
        do_reset();
        start = log_data.size(); v0 = viol;
        q0.delete(); q1.delete();
        q0.push_back(14'h0011); q1.push_back(14'h0022);
        fork
            sender(0, 0, 0);
            sender(1, 0, 0);
            receiver(2, 0, 0);
        join
        @(negedge clk);
        checks++;
        if (log_data.size() - start !== 2) begin errors++; $display("FAIL simul_count: got %0d grants expected 2", log_data.size() - start); end
        else begin
            checks++; if (log_data[start] !== 14'h0011)   begin errors++; $display("FAIL simul_first: got %h expected 0011", log_data[start]); end
            checks++; if (log_data[start+1] !== 14'h0022) begin errors++; $display("FAIL simul_second: got %h expected 0022", log_data[start+1]); end
        end
        checks++; if (grant_cnt0 !== 4'd1 || grant_cnt1 !== 4'd1) begin errors++; $display("FAIL simul_counters: got %0d/%0d expected 1/1", grant_cnt0, grant_cnt1); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL simul_protocol: got %0d violations expected 0", viol - v0); end
    endtask

    task automatic test_contention();
        int start, v0;
        do_reset();
        start = log_data.size(); v0 = viol;
        q0.delete(); q1.delete();
        for (int i = 0; i < 8; i++) begin q0.push_back(W'($urandom)); q1.push_back(W'($urandom)); end
        fork
            sender(0, 0, 0);
            sender(1, 0, 0);
            receiver(16, 0, 0);
        join
        @(negedge clk);
        run_model(start);
        checks++; if (model_bad !== 0) begin errors++; $display("FAIL cont_model_attrib: %0d grants unexplained, expected 0", model_bad); end
        checks++;
        if (log_data.size() - start !== 16) begin errors++; $display("FAIL cont_count: got %0d grants expected 16", log_data.size() - start); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (log_data[start+i] !== exp_data[i]) begin errors++; $display("FAIL cont_data[%0d]: got %h expected %h", i, log_data[start+i], exp_data[i]); end
                if (i > 0) begin
                    checks++;
                    if (log_cyc[start+i] - log_cyc[start+i-1] !== 4) begin errors++; $display("FAIL cont_period[%0d]: got %0d cycles expected 4", i, log_cyc[start+i] - log_cyc[start+i-1]); end
                end
            end
        end
        checks++; if (grant_cnt0 !== 4'd8 || grant_cnt1 !== 4'd8) begin errors++; $display("FAIL cont_counters: got %0d/%0d expected 8/8", grant_cnt0, grant_cnt1); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL cont_protocol: got %0d violations expected 0", viol - v0); end
    endtask

    task automatic test_one_sided(input int n, input string name);
        int start, a0, v0;
        do_reset();
        start = log_data.size(); a0 = ack0_rises; v0 = viol;
        q0.delete(); q1.delete();
        for (int i = 0; i < n; i++) q1.push_back(W'($urandom));
        fork
            sender(1, 0, 0);
            receiver(n, 0, 0);
        join
        @(negedge clk);
        run_model(start);
        checks++;
        if (log_data.size() - start !== n || model_bad !== 0) begin errors++; $display("FAIL %s_count: got %0d grants expected %0d", name, log_data.size() - start, n); end
        else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (log_data[start+i] !== exp_data[i]) begin errors++; $display("FAIL %s_data[%0d]: got %h expected %h", name, i, log_data[start+i], exp_data[i]); end
            end
        end
        checks++; if (grant_cnt1 !== CW'(n)) begin errors++; $display("FAIL %s_cnt1: got %0d expected %0d", name, grant_cnt1, n % (1 << CW)); end
        checks++; if (grant_cnt0 !== '0)     begin errors++; $display("FAIL %s_cnt0: got %0d expected 0", name, grant_cnt0); end
        checks++; if (ack0_rises !== a0)      begin errors++; $display("FAIL %s_in0_ack: got %0d pulses expected 0", name, ack0_rises - a0); end
        checks++; if (viol !== v0)            begin errors++; $display("FAIL %s_protocol: got %0d violations expected 0", name, viol - v0); end
    endtask

    task automatic test_slow_output();
        int start, v0;
        do_reset();
        start = log_data.size(); v0 = viol;
        q0.delete(); q1.delete();
        for (int i = 0; i < 4; i++) begin q0.push_back(W'($urandom)); q1.push_back(W'($urandom)); end
        fork
            sender(0, 0, 3);
            sender(1, 3, 6);
            receiver(8, 10, 10);
        join
        @(negedge clk);
        run_model(start);
        checks++; if (model_bad !== 0) begin errors++; $display("FAIL slow_model_attrib: %0d grants unexplained, expected 0", model_bad); end
        checks++;
        if (log_data.size() - start !== 8) begin errors++; $display("FAIL slow_count: got %0d grants expected 8", log_data.size() - start); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_data[start+i] !== exp_data[i]) begin errors++; $display("FAIL slow_data[%0d]: got %h expected %h", i, log_data[start+i], exp_data[i]); end
            end
        end
        checks++; if (grant_cnt0 !== 4'd4 || grant_cnt1 !== 4'd4) begin errors++; $display("FAIL slow_counters: got %0d/%0d expected 4/4", grant_cnt0, grant_cnt1); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL slow_protocol: got %0d violations expected 0", viol - v0); end
    endtask

    task automatic test_reset_mid();
        int start;
        do_reset();
        q0.delete(); q1.delete();
        q0.push_back(W'($urandom));
        fork
            sender(0, 0, 0);
            receiver(1, 0, 0);
        join
        in0_data = W'($urandom) | 14'h0001; in0_req = 1'b1;
        @(negedge clk);
        checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL rmid_in_send: out_req=%b expected 1", out_req); end
        rst_n = 1'b0; in0_req = 1'b0;
        @(negedge clk);
        checks++; if (out_req !== 1'b0 || in0_ack !== 1'b0 || in1_ack !== 1'b0) begin errors++; $display("FAIL rmid_handshake_outputs: req/ack0/ack1=%b%b%b expected 000", out_req, in0_ack, in1_ack); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rmid_out_data: got %h expected 0", out_data); end
        checks++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin errors++; $display("FAIL rmid_counters: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1); end
        rst_n = 1'b1;
        start = log_data.size();
        q0.delete(); q1.delete();
        q1.push_back(14'h3FFF);
        fork
            sender(1, 0, 0);
            receiver(1, 0, 0);
        join
        @(negedge clk);
        checks++;
        if (log_data.size() - start !== 1) begin errors++; $display("FAIL rmid_post_count: got %0d grants expected 1", log_data.size() - start); end
        else if (log_data[start] !== 14'h3FFF) begin errors++; $display("FAIL rmid_post_data: got %h expected 3fff", log_data[start]); end
        checks++; if (grant_cnt1 !== 4'd1 || grant_cnt0 !== 4'd0) begin errors++; $display("FAIL rmid_post_counters: got %0d/%0d expected 0/1", grant_cnt0, grant_cnt1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_contention();
        test_one_sided(5, "onesided");
        test_one_sided(17, "wrap");
        test_slow_output();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
